// File: rtl/top.sv
// Switch-to-LED mirror with a two-flop synchronizer, change counter and an
// eight-digit multiplexed hex display of the LEDs and the change count.
module top #(
    parameter int unsigned SCAN_DIV = 100000
) (
    input  logic        sys_clk,
    input  logic        rst_n,
    input  logic [23:0] switches_pin,
    output logic [23:0] leds_pin,
    output logic        sw_changed,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_data
);

    localparam int unsigned PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [23:0]   sync1_q, sync2_q, leds_q, leds_d;
    logic          changed_q, changed_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    digit_q, digit_d;
    logic [7:0]    seg_an_q, seg_an_d, seg_data_q, seg_data_d;
    logic [3:0]    nib;
    logic          wrap;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        unique case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            4'hF: hex7 = 7'h71;
        endcase
    endfunction

    // Display registers are fed from next-state values so digit, LEDs and counter stay in step.
    always_comb begin
        leds_d    = sync2_q;
        changed_d = (sync2_q != leds_q);
        cnt_d     = changed_d ? cnt_q + 8'd1 : cnt_q;
        wrap      = (presc_q == PRESC_MAX);
        presc_d   = wrap ? '0 : presc_q + 1'b1;
        digit_d   = wrap ? digit_q + 3'd1 : digit_q;
        nib       = 4'h0;
        unique case (digit_d)
            3'd0: nib = leds_d[3:0];
            3'd1: nib = leds_d[7:4];
            3'd2: nib = leds_d[11:8];
            3'd3: nib = leds_d[15:12];
            3'd4: nib = leds_d[19:16];
            3'd5: nib = leds_d[23:20];
            3'd6: nib = cnt_d[3:0];
            3'd7: nib = cnt_d[7:4];
        endcase
        seg_an_d   = ~(8'd1 << digit_d);
        seg_data_d = {1'b1, ~hex7(nib)};
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            leds_q     <= '0;
            changed_q  <= 1'b0;
            cnt_q      <= '0;
            presc_q    <= '0;
            digit_q    <= '0;
            seg_an_q   <= 8'hFE;
            seg_data_q <= 8'hC0;
        end else begin
            sync1_q    <= switches_pin;
            sync2_q    <= sync1_q;
            leds_q     <= leds_d;
            changed_q  <= changed_d;
            cnt_q      <= cnt_d;
            presc_q    <= presc_d;
            digit_q    <= digit_d;
            seg_an_q   <= seg_an_d;
            seg_data_q <= seg_data_d;
        end
    end

    assign leds_pin   = leds_q;
    assign sw_changed = changed_q;
    assign seg_an     = seg_an_q;
    assign seg_data   = seg_data_q;

endmodule

// File: tb/tb_top.sv
// Directed bench for top: switch sync latency, change pulses/counter, display scan, resets.
module tb_top;

    localparam int unsigned SCAN_DIV = 4;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] switches_pin = '0;
    logic [23:0] leds_pin;
    logic        sw_changed;
    logic [7:0]  seg_an;
    logic [7:0]  seg_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [23:0] exp_q[$];
    logic [23:0] leds_model = '0;
    logic [7:0]  cnt_model = '0;

    logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

    top #(.SCAN_DIV(SCAN_DIV)) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .switches_pin(switches_pin),
        .leds_pin    (leds_pin),
        .sw_changed  (sw_changed),
        .seg_an      (seg_an),
        .seg_data    (seg_data)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] seg_exp(input logic [3:0] n);
        logic [7:0] v;
        v = hex_tab[n];
        return ~v;
    endfunction

    function automatic logic [3:0] digit_val(input int d);
        if (d < 6) return leds_model[4*d +: 4];
        else if (d == 6) return cnt_model[3:0];
        else return cnt_model[7:4];
    endfunction

    // Scoreboard: every sw_changed pulse must match the oldest pushed switch value.
    always @(negedge sys_clk) begin
        if (rst_n && sw_changed) begin
            if (exp_q.size() == 0) check("unexpected_pulse", 32'(leds_pin), 32'hFFFF_FFFF);
            else check("pulse_value", 32'(leds_pin), 32'(exp_q.pop_front()));
        end
    end

    task automatic drive_sw(input logic [23:0] v, input int hold);
        @(negedge sys_clk);
        switches_pin = v;
        if (v != leds_model) begin
            exp_q.push_back(v);
            leds_model = v;
            cnt_model++;
        end
        repeat (hold) @(negedge sys_clk);
    endtask

    task automatic check_digit(input int d, input string tag);
        logic [7:0] an_exp;
        an_exp = ~(8'h01 << d);
        for (int i = 0; i < int'(SCAN_DIV) * 8 + 2 && seg_an !== an_exp; i++)
            @(negedge sys_clk);
        check({tag, "_an"}, 32'(seg_an), 32'(an_exp));
        check(tag, 32'(seg_data), 32'(seg_exp(digit_val(d))));
    endtask

    task automatic scan_check();
        logic [7:0] prev;
        logic [7:0] an_exp;
        bit found;
        found = 1'b0;
        prev = seg_an;
        for (int i = 0; i < int'(SCAN_DIV) * 10 && !found; i++) begin
            @(negedge sys_clk);
            if (seg_an == 8'hFE && prev != 8'hFE) found = 1'b1;
            prev = seg_an;
        end
        check("scan_sync", 32'(found), 32'd1);
        for (int d = 0; d < 8; d++) begin
            an_exp = ~(8'h01 << d);
            for (int k = 0; k < int'(SCAN_DIV); k++) begin
                check("scan_an", 32'(seg_an), 32'(an_exp));
                if (k == 0) check("scan_data", 32'(seg_data), 32'(seg_exp(digit_val(d))));
                @(negedge sys_clk);
            end
        end
        check("scan_wrap", 32'(seg_an), 32'hFE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-on reset held for 11 ns
        #10;
        check("rst_leds", 32'(leds_pin), 32'h0);
        check("rst_chg", 32'(sw_changed), 32'h0);
        check("rst_an", 32'(seg_an), 32'hFE);
        check("rst_data", 32'(seg_data), 32'hC0);
        #1 rst_n = 1'b1;

        // Latency: new value on leds on the 3rd rising edge, one-cycle pulse
        drive_sw(24'h000001, 0);
        for (int e = 1; e <= 2; e++) begin
            @(negedge sys_clk);
            check("lat_leds_early", 32'(leds_pin), 32'h0);
            check("lat_chg_early", 32'(sw_changed), 32'h0);
        end
        @(negedge sys_clk);
        check("lat_leds", 32'(leds_pin), 32'h000001);
        check("lat_chg", 32'(sw_changed), 32'h1);
        @(negedge sys_clk);
        check("lat_chg_off", 32'(sw_changed), 32'h0);
        repeat (5) @(negedge sys_clk);

        // Sequence 1 -> 3 -> 7, 100 ns apart
        drive_sw(24'h000003, 9);
        drive_sw(24'h000007, 9);
        check("seq_leds", 32'(leds_pin), 32'h000007);
        check("seq_pending", 32'(exp_q.size()), 32'd0);
        check_digit(6, "seq_cnt_lo");
        check_digit(7, "seq_cnt_hi");

        // Full scan with ABCDEF held
        drive_sw(24'hABCDEF, 6);
        scan_check();

        // Asynchronous reset mid-scan
        repeat (3) @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_leds", 32'(leds_pin), 32'h0);
        check("mid_chg", 32'(sw_changed), 32'h0);
        check("mid_an", 32'(seg_an), 32'hFE);
        check("mid_data", 32'(seg_data), 32'hC0);
        check("mid_pending", 32'(exp_q.size()), 32'd0);
        leds_model = '0;
        cnt_model  = '0;
        repeat (2) @(negedge sys_clk);
        rst_n = 1'b1;
        exp_q.push_back(24'hABCDEF);
        leds_model = 24'hABCDEF;
        cnt_model  = 8'd1;
        for (int e = 1; e <= 2; e++) begin
            @(negedge sys_clk);
            check("mid_reload_early", 32'(leds_pin), 32'h0);
        end
        @(negedge sys_clk);
        check("mid_reload", 32'(leds_pin), 32'hABCDEF);
        check("mid_reload_chg", 32'(sw_changed), 32'h1);
        @(negedge sys_clk);
        check("mid_reload_chg_off", 32'(sw_changed), 32'h0);
        check_digit(6, "mid_cnt_lo");

        // Clean reset with switches at zero, then 256 distinct changes
        @(negedge sys_clk);
        rst_n = 1'b0;
        switches_pin = '0;
        leds_model = '0;
        cnt_model  = '0;
        repeat (3) @(negedge sys_clk);
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        check("zero_leds", 32'(leds_pin), 32'h0);
        for (int i = 1; i <= 256; i++) drive_sw(24'(i), 4);
        repeat (4) @(negedge sys_clk);
        check("wrap_leds", 32'(leds_pin), 32'h000100);
        check("wrap_pending", 32'(exp_q.size()), 32'd0);
        check_digit(6, "wrap_cnt_lo");
        check("wrap_d6_c0", 32'(seg_data), 32'hC0);
        check_digit(7, "wrap_cnt_hi");
        check("wrap_d7_c0", 32'(seg_data), 32'hC0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 Parameter SCAN_DIV, default 100000, sets the number of sys_clk cycles each display digit stays lit; legal range is 2 or more.
REQ-002 sys_clk  input  1  system clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; asynchronous assert, active-low; the block has one clock and an asynchronous active-low reset.
REQ-004 switches_pin  input  24  raw board switches, asynchronous to sys_clk.
REQ-005 leds_pin  output  24  registered, synchronized copy of the switches.
REQ-006 sw_changed  output  1  one-cycle pulse when leds_pin takes a new value.
REQ-007 seg_an  output  8  seven-segment digit enables, active-low, one-hot-zero.
REQ-008 seg_data  output  8  segment drives, active-low; bit0=a … bit6=g, bit7=dp.

Function
REQ-009 The block SHALL pass switches_pin through a 2-flop synchronizer (sync1, then sync2) before any use.
REQ-010 leds_pin SHALL register sync2 every cycle, so a stable switch change appears on leds_pin on the 3rd rising edge after the change.
REQ-011 sw_changed SHALL be registered and high for exactly the one cycle in which leds_pin differs from its previous value.
REQ-012 sw_changed SHALL be low in every other cycle.
REQ-013 An 8-bit change counter SHALL increment once per sw_changed pulse and wrap from 255 to 0.
REQ-014 A prescaler SHALL count 0 to SCAN_DIV-1 and wrap.
REQ-015 On each prescaler wrap, a 3-bit digit index SHALL advance by one, wrapping from 7 to 0.
REQ-016 seg_an SHALL drive low only the bit selected by the digit index; all other bits are high.
REQ-017 Digits 0 to 5 SHALL show leds_pin nibbles [3:0], [7:4], [11:8], [15:12], [19:16] and [23:20] respectively.
REQ-018 Digits 6 and 7 SHALL show the change counter's low and high nibble respectively.
REQ-019 Hex decode SHALL use these active-high gfedcba values, inverted at the output:
- 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
- 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
REQ-020 seg_data bit7 (dp) SHALL always be 1 (off).
REQ-021 seg_an and seg_data SHALL be registered outputs, both derived from the same digit index, so they change together with no glitch.
REQ-022 If a switch change and a prescaler wrap occur in the same cycle, both SHALL take effect independently; a digit shows the leds_pin value as registered that cycle.
REQ-023 A switch toggle lasting less than 2 cycles may be missed; any value that reaches sync2 SHALL appear on leds_pin.

Reset
REQ-024 While rst_n=0, the following SHALL be 0: sync1, sync2, leds_pin, sw_changed, change counter, prescaler and digit index.
REQ-025 While rst_n=0, seg_an SHALL be 8'hFE and seg_data SHALL be 8'hC0 (digit 0 showing "0").
REQ-026 Assertion of rst_n SHALL take effect immediately, without waiting for a clock edge.
REQ-027 Normal operation SHALL resume on the first rising edge after rst_n deasserts.
REQ-028 Reset asserted mid-scan or mid-synchronization SHALL discard all in-flight state.
REQ-029 The first switch change after reset SHALL produce the usual sw_changed pulse.

Verification
REQ-030 Reset check: hold rst_n=0 for 11 ns with a 10 ns clock -> leds_pin=0, sw_changed=0, seg_an=FE, seg_data=C0.
REQ-031 Switch latency: after release, switches 0->000001 -> leds_pin=000001 on the 3rd edge, and sw_changed high for exactly that 1 cycle.
REQ-032 Switch sequence: 000001, then 000003, then 000007, each 100 ns apart -> 3 sw_changed pulses, change counter=3, leds_pin ends at 000007.
REQ-033 Scan check with SCAN_DIV=4 and switches=ABCDEF held:
- seg_an steps FE, FD, FB, …, 7F every 4 cycles, then wraps to FE.
- seg_data on digits 0 to 5 is ~71, ~79, ~5E, ~39, ~7C, ~77 (the nibbles of ABCDEF, low first), each with bit7=1.
REQ-034 Counter wrap: apply 256 distinct switch changes -> change counter returns to 0, and digits 6 and 7 both show "0" (C0).
REQ-035 Mid-operation reset: pulse rst_n low mid-scan while switches are nonzero -> outputs match REQ-024/REQ-025 immediately; after release, leds_pin reloads 3 edges later with one sw_changed pulse.
